// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter: inhibit, request-to-send, clock out 10 bits on device clock, check ACK.
// Edge response 3 clk after the line moves; txStart ignored while busy. Build with PS2_TX_RETRY_EN for one automatic retry.
module ps2_host_tx #(
    parameter int counterBits   = 16,
    parameter int inhibitCycles = 1000,
    parameter int timeoutCycles = 40000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] txData,
    input  logic       txStart,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       rxInhibit,
    input  logic       ps2ClkIn,
    input  logic       ps2DataIn,
    output logic       ps2ClkDriveLow,
    output logic       ps2DataDriveLow
);

`ifdef PS2_TX_RETRY_EN
    typedef enum logic [2:0] {
        IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE, RETRY_WAIT
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE
    } state_t;
`endif

    localparam logic [counterBits-1:0] INHIBIT_LAST = counterBits'(inhibitCycles - 1);
    localparam logic [counterBits-1:0] TIMEOUT_LAST = counterBits'(timeoutCycles - 1);

    state_t                 state;
    logic [counterBits-1:0] counter;
    logic [counterBits-1:0] counterNext;
    logic [3:0]             bitIdx;
    logic [9:0]             shiftReg;
    logic [1:0]             clkSync;
    logic [1:0]             dataSync;
    logic                   clkPrev;
    logic                   clkSynced;
    logic                   dataSynced;
    logic                   clkFall;
    logic                   busIdle;
    logic                   timeoutHit;
    logic                   failNow;
`ifdef PS2_TX_RETRY_EN
    logic                   retried;
`endif

    assign clkSynced  = clkSync[1];
    assign dataSynced = dataSync[1];
    assign clkFall    = clkPrev & ~clkSynced;
    assign busIdle    = clkSynced & dataSynced;
    assign rxInhibit  = busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clkSync  <= 2'b11;
            dataSync <= 2'b11;
            clkPrev  <= 1'b1;
        end else begin
            clkSync  <= {clkSync[0], ps2ClkIn};
            dataSync <= {dataSync[0], ps2DataIn};
            clkPrev  <= clkSync[1];
        end
    end

    always_comb begin
        counterNext = (counter == '1) ? counter : counter + 1'b1;
        timeoutHit  = 1'b0;
        if (counter == TIMEOUT_LAST) begin
            case (state)
                SEND, ACK: timeoutHit = ~clkFall;
                WAIT_IDLE: timeoutHit = ~busIdle;
                default:   timeoutHit = 1'b0;
            endcase
        end
        // A missing ACK and a timeout share one abort path.
        failNow = timeoutHit | ((state == ACK) & clkFall & dataSynced);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            counter         <= '0;
            bitIdx          <= '0;
            shiftReg        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            ps2ClkDriveLow  <= 1'b0;
            ps2DataDriveLow <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retried         <= 1'b0;
`endif
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (failNow) begin
                ps2ClkDriveLow  <= 1'b0;
                ps2DataDriveLow <= 1'b0;
                counter         <= '0;
`ifdef PS2_TX_RETRY_EN
                if (!retried) begin
                    retried <= 1'b1;
                    state   <= RETRY_WAIT;
                end else begin
                    error <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
`else
                error <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        // The cycle carrying done/error still counts as busy for requests.
                        if (txStart && !done && !error) begin
                            shiftReg       <= {1'b1, ~^txData, txData};
                            busy           <= 1'b1;
                            counter        <= '0;
                            ps2ClkDriveLow <= 1'b1;
                            state          <= INHIBIT;
`ifdef PS2_TX_RETRY_EN
                            retried        <= 1'b0;
`endif
                        end
                    end
                    INHIBIT: begin
                        if (counter == INHIBIT_LAST) begin
                            ps2ClkDriveLow  <= 1'b0;
                            ps2DataDriveLow <= 1'b1;
                            counter         <= '0;
                            state           <= REQ;
                        end else begin
                            counter <= counterNext;
                        end
                    end
                    REQ: begin
                        counter <= '0;
                        bitIdx  <= '0;
                        state   <= SEND;
                    end
                    SEND: begin
                        if (clkFall) begin
                            ps2DataDriveLow <= ~shiftReg[bitIdx];
                            bitIdx          <= bitIdx + 1'b1;
                            counter         <= '0;
                            if (bitIdx == 4'd9) begin
                                state <= ACK;
                            end
                        end else begin
                            counter <= counterNext;
                        end
                    end
                    ACK: begin
                        ps2DataDriveLow <= 1'b0;
                        if (clkFall) begin
                            counter <= '0;
                            state   <= WAIT_IDLE;
                        end else begin
                            counter <= counterNext;
                        end
                    end
                    WAIT_IDLE: begin
                        if (busIdle) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            counter <= counterNext;
                        end
                    end
`ifdef PS2_TX_RETRY_EN
                    RETRY_WAIT: begin
                        if (counter == INHIBIT_LAST) begin
                            counter        <= '0;
                            ps2ClkDriveLow <= 1'b1;
                            state          <= INHIBIT;
                        end else begin
                            counter <= counterNext;
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboarded bench for ps2_host_tx with an open-drain keyboard model; honours PS2_TX_RETRY_EN.
module tb_ps2_host_tx;
    localparam int INH  = 1000;
    localparam int TMO  = 2000;
    localparam int HALF = 80;
    localparam logic [1:0] EV_DONE = 2'b01;
    localparam logic [1:0] EV_ERR  = 2'b10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] txData = 8'h00;
    logic       txStart = 1'b0;
    logic       busy, done, error, rxInhibit;
    logic       ps2ClkIn, ps2DataIn, ps2ClkDriveLow, ps2DataDriveLow;
    logic       devClk = 1'b1;
    logic       devData = 1'b1;

    assign ps2ClkIn  = devClk & ~ps2ClkDriveLow;
    assign ps2DataIn = devData & ~ps2DataDriveLow;

    ps2_host_tx #(
        .counterBits  (16),
        .inhibitCycles(INH),
        .timeoutCycles(TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .txData         (txData),
        .txStart        (txStart),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .rxInhibit      (rxInhibit),
        .ps2ClkIn       (ps2ClkIn),
        .ps2DataIn      (ps2DataIn),
        .ps2ClkDriveLow (ps2ClkDriveLow),
        .ps2DataDriveLow(ps2DataDriveLow)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] expQ[$];
    int         inhQ[$];
    logic       bitQ[$];
    int         lowCnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pushFrame(input logic [7:0] d);
        for (int i = 0; i < 8; i++) bitQ.push_back(d[i]);
        bitQ.push_back(~^d);
        bitQ.push_back(1'b1);
        inhQ.push_back(INH);
    endtask

    // Monitor: inhibit length and done/error pulses against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            lowCnt = 0;
        end else begin
            if (ps2ClkDriveLow) begin
                lowCnt++;
            end else if (lowCnt > 0) begin
                if (inhQ.size() == 0) check("inhibit_unexpected", lowCnt, 0);
                else check("inhibit_len", lowCnt, inhQ.pop_front());
                lowCnt = 0;
            end
            if (done || error) begin
                if (expQ.size() == 0) check("event_unexpected", {error, done}, 2'b00);
                else check("event_kind", {error, done}, expQ.pop_front());
                check("busy_drop", {busy, rxInhibit}, 2'b00);
            end
        end
    end

    task automatic startTx(input logic [7:0] d);
        @(negedge clk);
        txData  = d;
        txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
    endtask

    // Keyboard model: waits for request-to-send, clocks nFalls edges, samples data on rising edges.
    task automatic runDevice(input int nFalls, input bit giveAck);
        int n = 0;
        while (!(ps2DataDriveLow && !ps2ClkDriveLow) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", (n < 5000), 1);
        if (n >= 5000) return;
        repeat (40) @(negedge clk);
        for (int k = 1; k <= nFalls; k++) begin
            if (k == 11 && giveAck) devData = 1'b0;
            devClk = 1'b0;
            repeat (HALF) @(negedge clk);
            devClk = 1'b1;
            if (k <= 10) begin
                if (bitQ.size() == 0) check($sformatf("bit%0d_unexpected", k - 1), ps2DataIn, 1'bx);
                else check($sformatf("frame_bit%0d", k - 1), ps2DataIn, bitQ.pop_front());
            end
            if (k == 11) devData = 1'b1;
            if (k < nFalls) repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_finished"}, busy, 0);
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lim;
        logic prev;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_rxInhibit", rxInhibit, 0);
        check("rst_clkDrive", ps2ClkDriveLow, 0);
        check("rst_dataDrive", ps2DataDriveLow, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // LED command 0xED
        pushFrame(8'hED);
        expQ.push_back(EV_DONE);
        startTx(8'hED);
        check("ed_busy", busy, 1);
        runDevice(11, 1);
        waitIdle("ed");

        // Parity on 0x00, then 0x01 requested in the done cycle (ignored) and the next (accepted)
        repeat (10) @(negedge clk);
        pushFrame(8'h00);
        expQ.push_back(EV_DONE);
        startTx(8'h00);
        runDevice(11, 1);
        waitIdle("p00");
        check("p00_done_now", done, 1);
        txData  = 8'h01;
        txStart = 1'b1;
        pushFrame(8'h01);
        expQ.push_back(EV_DONE);
        @(negedge clk);
        check("start_in_done_cycle_ignored", busy, 0);
        @(negedge clk);
        txStart = 1'b0;
        check("start_next_cycle_accepted", busy, 1);
        runDevice(11, 1);
        waitIdle("p01");

        // Missing ACK
        repeat (10) @(negedge clk);
        pushFrame(8'hEE);
`ifdef PS2_TX_RETRY_EN
        pushFrame(8'hEE);
`endif
        expQ.push_back(EV_ERR);
        startTx(8'hEE);
        runDevice(11, 0);
`ifdef PS2_TX_RETRY_EN
        runDevice(11, 0);
`endif
        waitIdle("noack");
        check("noack_release", {ps2ClkDriveLow, ps2DataDriveLow}, 2'b00);

        // Device never clocks: error TMO cycles after REQ ends
        repeat (10) @(negedge clk);
        inhQ.push_back(INH);
`ifdef PS2_TX_RETRY_EN
        inhQ.push_back(INH);
`endif
        expQ.push_back(EV_ERR);
        startTx(8'h55);
        n = 0;
        lim = 0;
        prev = 1'b0;
        while (!error && lim < 10000) begin
            @(negedge clk);
            lim++;
            if (ps2DataDriveLow && !prev) n = 0;
            else n++;
            prev = ps2DataDriveLow;
        end
        check("timeout_error_seen", error, 1);
        check("timeout_latency", n, TMO + 1);
        check("timeout_release", {ps2ClkDriveLow, ps2DataDriveLow}, 2'b00);

        // Asynchronous reset after bit 4 of 0xA5
        repeat (10) @(negedge clk);
        inhQ.push_back(INH);
        bitQ.push_back(1'b1);
        bitQ.push_back(1'b0);
        bitQ.push_back(1'b1);
        bitQ.push_back(1'b0);
        bitQ.push_back(1'b0);
        startTx(8'hA5);
        runDevice(5, 0);
        check("pre_reset_data_low", ps2DataDriveLow, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check("rst_async_all_low", {ps2ClkDriveLow, ps2DataDriveLow, busy, done, error}, 5'b0);
        repeat (3) @(negedge clk);
        devClk = 1'b1;
        reset  = 1'b0;
        repeat (5) @(negedge clk);
        pushFrame(8'hFF);
        expQ.push_back(EV_DONE);
        startTx(8'hFF);
        runDevice(11, 1);
        waitIdle("ff");

        // Second request during INHIBIT is ignored
        repeat (10) @(negedge clk);
        pushFrame(8'h3C);
        expQ.push_back(EV_DONE);
        startTx(8'h3C);
        repeat (48) @(negedge clk);
        txData  = 8'hC3;
        txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
        check("second_start_still_inhibit", {busy, ps2ClkDriveLow}, 2'b11);
        runDevice(11, 1);
        waitIdle("dup");
        repeat (1500) @(negedge clk);
        check("no_second_frame", busy, 0);

        check("events_left", expQ.size(), 0);
        check("inhibits_left", inhQ.size(), 0);
        check("bits_left", bitQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends command bytes such as LED set (0xED), reset (0xFF) and echo (0xEE) to the keyboard over the same open-drain clock and data lines that the keyboard decoder receives on. The processor or a small keyboard-control block drives it with a byte/strobe handshake. While it owns the bus it asserts rxInhibit so the receiver ignores the frame.

Parameters:
counterBits, 16, width of the inhibit/timeout counter
inhibitCycles, 1000, clk cycles the host holds ps2Clk low (at least 100 us)
timeoutCycles, 40000, maximum clk cycles between device falling edges, and to the first edge, before aborting

Ports:
clk  input  1  system clock (the single clock)
reset  input  1  asynchronous, active-high reset
txData  input  8  byte to send; sampled when txStart is accepted
txStart  input  1  one-cycle request; ignored while busy=1
busy  output  1  high from acceptance until done/error
done  output  1  one-cycle pulse: frame acknowledged and bus idle
error  output  1  one-cycle pulse: timeout or missing ACK
rxInhibit  output  1  equals busy; the receiver discards bits while high
ps2ClkIn  input  1  raw PS/2 clock line (asynchronous)
ps2DataIn  input  1  raw PS/2 data line (asynchronous)
ps2ClkDriveLow  output  1  1 = pull clock line low; 0 = release (tri-state)
ps2DataDriveLow  output  1  1 = pull data line low; 0 = release

Behaviour:
- Reset (asynchronous, immediate):
  - State IDLE; ps2ClkDriveLow=0, ps2DataDriveLow=0 (bus released).
  - busy=0, done=0, error=0; counter and bit index cleared; synchronisers set to 1.
- Input sync: ps2ClkIn and ps2DataIn each pass a 2-FF synchroniser.
  - clkFall = synced clock was 1 last cycle and is 0 now.
  - Edge detection latency is 3 clk cycles after the line moves.
- Frame: start bit 0, data[0..7] LSB first, odd parity (~^txData), stop bit 1, then device ACK (data low).
- IDLE:
  - txStart=1 latches txData and parity into shiftReg[9:0] = {1'b1 stop, parity, data}.
  - busy goes 1 the next cycle; counter=0; go INHIBIT.
- INHIBIT: ps2ClkDriveLow=1, data released; counter increments. At counter==inhibitCycles-1, go REQ.
- REQ, one cycle: ps2DataDriveLow=1 (start bit), ps2ClkDriveLow=0; counter=0; bitIdx=0; go SEND.
- SEND, on each clkFall:
  - ps2DataDriveLow = ~shiftReg[bitIdx]; bitIdx++.
  - This drives data0..7, parity, then stop (a stop bit of 1 means release).
  - After the 10th clkFall (stop bit placed), go ACK.
  - Counter resets on every clkFall and otherwise increments.
- ACK: data released. On clkFall, sample synced data:
  - 0 → go WAIT_IDLE.
  - 1 → error pulse, go IDLE.
- WAIT_IDLE: when synced clock and synced data are both 1, pulse done for 1 cycle, busy=0, go IDLE.
- Timeout: in SEND, ACK and WAIT_IDLE, if counter reaches timeoutCycles-1 then:
  - error pulse for 1 cycle;
  - both drives released in that same cycle;
  - busy=0 and go IDLE.
- done and error are mutually exclusive, and each lasts exactly 1 cycle.
- busy drops in the same cycle as the done/error pulse. A txStart in that cycle is ignored; a txStart on the next cycle is accepted.
- Device-initiated activity (clkFall) while IDLE is ignored by this block.
- The counter saturates and never wraps.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined:
  - On the first timeout or missing ACK of a request, the block does not pulse error.
  - It releases the bus for inhibitCycles, then restarts from INHIBIT with the same latched byte. busy stays 1 throughout.
  - error is pulsed only if the retry also fails. A success on the retry gives a normal done.
- Undefined: the first failure pulses error immediately. No retry logic or retry flag is synthesised.

Test Plan:
1. txData=0xED, txStart; device model clocks at 80 cycles/half-period and ACKs → clock held low exactly 1000 cycles; the data bits driven are 1,0,1,1,0,1,1,1 then parity 1 and stop released; done pulses once; busy high until done.
2. txData=0x00 → parity bit 1; txData=0x01 → parity bit 0; each checked at the 9th clkFall.
3. Device clocks the frame but keeps data high at the 11th falling edge → error pulse; done never pulses; both drives 0 afterwards.
4. Device never clocks after REQ → error exactly timeoutCycles cycles after REQ; lines released. With PS2_TX_RETRY_EN, a second INHIBIT phase is seen and error follows only the second timeout.
5. Assert reset mid-SEND (after bit 4) → drives, busy, done and error all go 0 immediately without a clock edge; a following txStart=0xFF completes normally.
6. txStart pulsed at cycles 5 and 50 of INHIBIT → the second pulse is ignored; a single frame carrying the original byte is sent.
